// File: rtl/layer_serializer.sv
// Layer serializer: captures all neuron outputs of one layer in a single
// cycle and replays them, neuron 0 first, as a one-word-per-cycle stream
// that feeds the neuron_in / neuron_in_valid inputs of the next layer.
module layer_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [numNeurons-1:0]            layer_in_valid,
  input  logic [numNeurons*dataWidth-1:0]  layer_in,
  output logic [dataWidth-1:0]             data_out,
  output logic                             data_out_valid,
  output logic                             busy,
  output logic                             frame_err
);

  localparam int CntW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(numNeurons - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [numNeurons*dataWidth-1:0] sreg_q, sreg_d;
  logic [dataWidth-1:0]            data_out_q, data_out_d;
  logic                            valid_q, valid_d;
  logic                            busy_q, busy_d;
  logic                            err_q, err_d;

  logic capture;
  logic partial;
  logic last_word;

  // Classify the per-cycle upstream valid pattern and the frame position.
  always_comb begin
    capture   = &layer_in_valid;
    partial   = (|layer_in_valid) & ~capture;
    last_word = (cnt_q == LastCnt);
  end

  // Next-state, shift-register and registered-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    err_d      = err_q;
    data_out_d = '0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          sreg_d  = layer_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (partial) begin
          err_d = 1'b1;
        end
      end

      SHIFT: begin
        // Word 0 sits in the low slice; shifting right exposes the next one.
        data_out_d = sreg_q[dataWidth-1:0];
        valid_d    = 1'b1;
        busy_d     = 1'b1;
        sreg_d     = sreg_q >> dataWidth;
        cnt_d      = cnt_q + CntW'(1);
        if (last_word) begin
          cnt_d = '0;
          if (capture) begin
            // Back-to-back frame: reload while the last word goes out.
            sreg_d = layer_in;
          end else begin
            state_d = IDLE;
            if (partial) err_d = 1'b1;
          end
        end else if (capture || partial) begin
          // Overrun: the frame in flight is kept, the new data is dropped.
          err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift register is reset too, so a frame cut short by reset
    // leaves no stale words behind to be replayed later.
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sreg_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;
  assign busy           = busy_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer with numNeurons=4, dataWidth=16.
module tb_layer_serializer;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     layer_in_valid;
  logic [N*W-1:0]   layer_in;
  logic [W-1:0]     data_out;
  logic             data_out_valid;
  logic             busy;
  logic             frame_err;

  int checks   = 0;
  int failures = 0;

  layer_serializer #(.numNeurons(N), .dataWidth(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .layer_in_valid (layer_in_valid),
    .layer_in       (layer_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .busy           (busy),
    .frame_err      (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame A words {0x0100,0xFF80,0x7FFF,0x0000}; frame B {0x1111..0x4444}.
  localparam logic [N*W-1:0] FRAME_A = 64'h0000_7FFF_FF80_0100;
  localparam logic [N*W-1:0] FRAME_B = 64'h4444_3333_2222_1111;

  typedef struct {
    logic           rst_n;
    logic [N-1:0]   vld;
    logic [N*W-1:0] data;
    logic           e_valid;
    logic [W-1:0]   e_data;
    logic           e_busy;
    logic           e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d,
                     input logic ev, input logic [W-1:0] ed, input logic eb, input logic ee);
    vec_t t;
    t.rst_n = r; t.vld = v; t.data = d;
    t.e_valid = ev; t.e_data = ed; t.e_busy = eb; t.e_err = ee;
    vecs.push_back(t);
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [W-1:0] ed,
                            input logic eb, input logic ee);
    check({tag, ".valid"}, 64'(data_out_valid), 64'(ev));
    check({tag, ".data"},  64'(data_out),       64'(ed));
    check({tag, ".busy"},  64'(busy),           64'(eb));
    check({tag, ".err"},   64'(frame_err),      64'(ee));
  endtask

  initial begin
    logic [N*W-1:0] fb;
    rst_n = 1'b0;
    layer_in_valid = '0;
    layer_in = '0;

    // Test 2: single frame.
    add(1, 4'hF, FRAME_A, 0, 16'h0000, 0, 0);
    add(1, 4'h0, '0,      1, 16'h0100, 1, 0);
    add(1, 4'h0, '0,      1, 16'hFF80, 1, 0);
    add(1, 4'h0, '0,      1, 16'h7FFF, 1, 0);
    add(1, 4'h0, '0,      1, 16'h0000, 1, 0);
    add(1, 4'h0, '0,      0, 16'h0000, 0, 0);
    // Test 3: back-to-back, second capture with the last word of the first.
    add(1, 4'hF, FRAME_A, 0, 16'h0000, 0, 0);
    add(1, 4'h0, '0,      1, 16'h0100, 1, 0);
    add(1, 4'h0, '0,      1, 16'hFF80, 1, 0);
    add(1, 4'h0, '0,      1, 16'h7FFF, 1, 0);
    add(1, 4'hF, FRAME_B, 1, 16'h0000, 1, 0);
    add(1, 4'h0, '0,      1, 16'h1111, 1, 0);
    add(1, 4'h0, '0,      1, 16'h2222, 1, 0);
    add(1, 4'h0, '0,      1, 16'h3333, 1, 0);
    add(1, 4'h0, '0,      1, 16'h4444, 1, 0);
    add(1, 4'h0, '0,      0, 16'h0000, 0, 0);
    // Test 4: overrun 2 cycles into a frame.
    add(1, 4'hF, FRAME_A, 0, 16'h0000, 0, 0);
    add(1, 4'h0, '0,      1, 16'h0100, 1, 0);
    add(1, 4'hF, FRAME_B, 1, 16'hFF80, 1, 1);
    add(1, 4'h0, '0,      1, 16'h7FFF, 1, 1);
    add(1, 4'h0, '0,      1, 16'h0000, 1, 1);
    add(1, 4'h0, '0,      0, 16'h0000, 0, 1);
    add(1, 4'h0, '0,      0, 16'h0000, 0, 1);
    add(1, 4'h0, '0,      0, 16'h0000, 0, 1);
    // Reset clears the sticky flag, then test 5: partial valid in IDLE.
    add(0, 4'h0, '0,      0, 16'h0000, 0, 0);
    add(1, 4'h5, FRAME_B, 0, 16'h0000, 0, 1);
    add(1, 4'h0, '0,      0, 16'h0000, 0, 1);
    add(1, 4'hF, FRAME_B, 0, 16'h0000, 0, 1);
    add(1, 4'h0, '0,      1, 16'h1111, 1, 1);
    add(1, 4'h0, '0,      1, 16'h2222, 1, 1);
    add(1, 4'h0, '0,      1, 16'h3333, 1, 1);
    add(1, 4'h0, '0,      1, 16'h4444, 1, 1);
    add(1, 4'h0, '0,      0, 16'h0000, 0, 1);

    // Test 1: reset then 20 idle cycles.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check_outs($sformatf("idle%0d", c), 0, 16'h0000, 0, 0);
    end

    // Tests 2-5 from the vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n          = vecs[i].rst_n;
      layer_in_valid = vecs[i].vld;
      layer_in       = vecs[i].data;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                 vecs[i].e_busy, vecs[i].e_err);
    end
    layer_in_valid = '0;
    layer_in = '0;

    // Test 6: async reset mid-frame, off the clock edge.
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    layer_in_valid = 4'hF; layer_in = FRAME_A;
    @(posedge clk); #1 layer_in_valid = '0; layer_in = '0;
    @(posedge clk); @(posedge clk); #1;
    check_outs("mid.pre", 1, 16'hFF80, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check_outs("mid.rst", 0, 16'h0000, 0, 0);
    @(posedge clk); #1;
    check_outs("mid.held", 0, 16'h0000, 0, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_outs("mid.norepl", 0, 16'h0000, 0, 0);
    end
    layer_in_valid = 4'hF; layer_in = FRAME_B;
    @(posedge clk); #1 layer_in_valid = '0; layer_in = '0;
    fb = FRAME_B;
    for (int w = 0; w < N; w++) begin
      @(posedge clk); #1;
      check_outs($sformatf("post.w%0d", w), 1, fb[w*W +: W], 1, 0);
    end
    @(posedge clk); #1;
    check_outs("post.end", 0, 16'h0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
